// File: rtl/axi_rd_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : axi_rd_arbiter
// Brief    : Two-master to one-slave AXI read arbiter, one transaction in
//            flight; round-robin or fixed (m1-first) priority on ties.
// Revision : 1.0  initial release
// ============================================================================
module axi_rd_arbiter #(
    parameter int FIXED_PRIO = 0
) (
    input  logic        clock,
    input  logic        reset,
    // master 0 (IFU)
    input  logic [31:0] m0_araddr,
    input  logic        m0_arvalid,
    input  logic [3:0]  m0_arid,
    input  logic [7:0]  m0_arlen,
    input  logic [2:0]  m0_arsize,
    input  logic [1:0]  m0_arburst,
    output logic        m0_arready,
    input  logic        m0_rready,
    output logic [31:0] m0_rdata,
    output logic [1:0]  m0_rresp,
    output logic        m0_rvalid,
    output logic        m0_rlast,
    output logic [3:0]  m0_rid,
    // master 1 (LSU)
    input  logic [31:0] m1_araddr,
    input  logic        m1_arvalid,
    input  logic [3:0]  m1_arid,
    input  logic [7:0]  m1_arlen,
    input  logic [2:0]  m1_arsize,
    input  logic [1:0]  m1_arburst,
    output logic        m1_arready,
    input  logic        m1_rready,
    output logic [31:0] m1_rdata,
    output logic [1:0]  m1_rresp,
    output logic        m1_rvalid,
    output logic        m1_rlast,
    output logic [3:0]  m1_rid,
    // shared downstream port
    output logic [31:0] s_araddr,
    output logic        s_arvalid,
    output logic [3:0]  s_arid,
    output logic [7:0]  s_arlen,
    output logic [2:0]  s_arsize,
    output logic [1:0]  s_arburst,
    input  logic        s_arready,
    input  logic [31:0] s_rdata,
    input  logic [1:0]  s_rresp,
    input  logic        s_rvalid,
    input  logic        s_rlast,
    input  logic [3:0]  s_rid,
    output logic        s_rready
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ADDR = 2'd1;
    localparam logic [1:0] S_DATA = 2'd2;

    logic [1:0] r_state;
    logic [1:0] w_state_nxt;
    logic       r_gnt;
    logic       w_gnt_nxt;
    logic       r_lst;
    logic       w_lst_nxt;
    logic       w_winner;
    logic       w_gnt_arvalid;
    logic       w_gnt_rready;
    logic       w_addr_ph;
    logic       w_data_ph;

    // lst resets to 1 so that the first tie goes to m0
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_gnt   <= 1'b0;
            r_lst   <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_gnt   <= w_gnt_nxt;
            r_lst   <= w_lst_nxt;
        end
    end

    assign w_gnt_arvalid = r_gnt ? m1_arvalid : m0_arvalid;
    assign w_gnt_rready  = r_gnt ? m1_rready  : m0_rready;

    always_comb begin
        if (m0_arvalid && m1_arvalid) begin
            w_winner = (FIXED_PRIO != 0) ? 1'b1 : ~r_lst;
        end else begin
            w_winner = m1_arvalid;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_gnt_nxt   = r_gnt;
        w_lst_nxt   = r_lst;
        case (r_state)
            S_IDLE: begin
                if (m0_arvalid || m1_arvalid) begin
                    w_state_nxt = S_ADDR;
                    w_gnt_nxt   = w_winner;
                end
            end
            S_ADDR: begin
                if (w_gnt_arvalid && s_arready) begin
                    w_state_nxt = S_DATA;
                end
            end
            S_DATA: begin
                if (s_rvalid && w_gnt_rready && s_rlast) begin
                    w_state_nxt = S_IDLE;
                    w_lst_nxt   = r_gnt;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // handshake outputs are held low while reset is asserted, whatever the state
    always_comb begin
        w_addr_ph  = (r_state == S_ADDR) && !reset;
        w_data_ph  = (r_state == S_DATA) && !reset;

        s_araddr   = r_gnt ? m1_araddr  : m0_araddr;
        s_arid     = r_gnt ? m1_arid    : m0_arid;
        s_arlen    = r_gnt ? m1_arlen   : m0_arlen;
        s_arsize   = r_gnt ? m1_arsize  : m0_arsize;
        s_arburst  = r_gnt ? m1_arburst : m0_arburst;
        s_arvalid  = w_addr_ph && w_gnt_arvalid;
        m0_arready = w_addr_ph && !r_gnt && s_arready;
        m1_arready = w_addr_ph &&  r_gnt && s_arready;

        s_rready   = w_data_ph && w_gnt_rready;
        m0_rvalid  = w_data_ph && !r_gnt && s_rvalid;
        m1_rvalid  = w_data_ph &&  r_gnt && s_rvalid;
        m0_rdata   = s_rdata;
        m0_rresp   = s_rresp;
        m0_rlast   = s_rlast;
        m0_rid     = s_rid;
        m1_rdata   = s_rdata;
        m1_rresp   = s_rresp;
        m1_rlast   = s_rlast;
        m1_rid     = s_rid;
    end

endmodule
`default_nettype wire

// File: tb/tb_axi_rd_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_axi_rd_arbiter
// Brief    : Two arbiters (round-robin and fixed priority) on shared stimulus,
//            checked every cycle against a transaction-level ownership model.
// Revision : 1.0  initial release
// ============================================================================
module tb_axi_rd_arbiter;

    logic clock = 1'b0;
    logic reset = 1'b1;

    // master-side inputs, index = master
    logic [1:0]       arvalid = '0;
    logic [1:0][31:0] araddr  = '0;
    logic [1:0][3:0]  arid    = '0;
    logic [1:0][7:0]  arlen   = '0;
    logic [1:0][2:0]  arsize  = '0;
    logic [1:0][1:0]  arburst = '0;
    logic [1:0]       rready  = '0;

    // slave-side inputs
    logic        s_arready = 1'b0;
    logic [31:0] s_rdata   = '0;
    logic [1:0]  s_rresp   = '0;
    logic        s_rvalid  = 1'b0;
    logic        s_rlast   = 1'b0;
    logic [3:0]  s_rid     = '0;

    // outputs, index [instance][master]; instance 0 round-robin, 1 fixed
    logic [1:0][1:0]       arready;
    logic [1:0][1:0]       rvalid;
    logic [1:0][1:0][31:0] rdata;
    logic [1:0][1:0][1:0]  rresp;
    logic [1:0][1:0]       rlast;
    logic [1:0][1:0][3:0]  rid;
    logic [1:0][31:0]      s_araddr;
    logic [1:0]            s_arvalid;
    logic [1:0][3:0]       s_arid;
    logic [1:0][7:0]       s_arlen;
    logic [1:0][2:0]       s_arsize;
    logic [1:0][1:0]       s_arburst;
    logic [1:0]            s_rready;

    int n_chk = 0;
    int n_err = 0;

    always #5 clock = ~clock;

    for (genvar i = 0; i < 2; i++) begin : g_dut
        axi_rd_arbiter #(.FIXED_PRIO(i)) u_dut (
            .clock(clock), .reset(reset),
            .m0_araddr(araddr[0]), .m0_arvalid(arvalid[0]), .m0_arid(arid[0]),
            .m0_arlen(arlen[0]), .m0_arsize(arsize[0]), .m0_arburst(arburst[0]),
            .m0_arready(arready[i][0]), .m0_rready(rready[0]),
            .m0_rdata(rdata[i][0]), .m0_rresp(rresp[i][0]), .m0_rvalid(rvalid[i][0]),
            .m0_rlast(rlast[i][0]), .m0_rid(rid[i][0]),
            .m1_araddr(araddr[1]), .m1_arvalid(arvalid[1]), .m1_arid(arid[1]),
            .m1_arlen(arlen[1]), .m1_arsize(arsize[1]), .m1_arburst(arburst[1]),
            .m1_arready(arready[i][1]), .m1_rready(rready[1]),
            .m1_rdata(rdata[i][1]), .m1_rresp(rresp[i][1]), .m1_rvalid(rvalid[i][1]),
            .m1_rlast(rlast[i][1]), .m1_rid(rid[i][1]),
            .s_araddr(s_araddr[i]), .s_arvalid(s_arvalid[i]), .s_arid(s_arid[i]),
            .s_arlen(s_arlen[i]), .s_arsize(s_arsize[i]), .s_arburst(s_arburst[i]),
            .s_arready(s_arready), .s_rdata(s_rdata), .s_rresp(s_rresp),
            .s_rvalid(s_rvalid), .s_rlast(s_rlast), .s_rid(s_rid),
            .s_rready(s_rready[i])
        );
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Model: who owns the slave (-1 none), whether its address went out,
    // who wins the next tie, and the order in which addresses were issued.
    int own   [2] = '{-1, -1};
    bit adone [2] = '{1'b0, 1'b0};
    int pref  [2] = '{0, 0};
    int gq0[$];
    int gq1[$];

    always @(posedge clock) begin
        for (int k = 0; k < 2; k++) begin
            if (reset) begin
                own[k] = -1; adone[k] = 1'b0; pref[k] = 0;
                if (k == 0) gq0.delete(); else gq1.delete();
            end else if (own[k] < 0) begin
                if (arvalid[0] && arvalid[1]) own[k] = (k == 1) ? 1 : pref[k];
                else if (arvalid[0]) own[k] = 0;
                else if (arvalid[1]) own[k] = 1;
                adone[k] = 1'b0;
            end else if (!adone[k]) begin
                if (arvalid[own[k]] && s_arready) begin
                    adone[k] = 1'b1;
                    if (k == 0) gq0.push_back(own[k]); else gq1.push_back(own[k]);
                end
            end else if (s_rvalid && rready[own[k]] && s_rlast) begin
                pref[k] = 1 - own[k];
                own[k] = -1;
            end
        end
    end

    // per-cycle comparison against the model, away from the active edge
    initial begin
        logic [5:0] e;
        logic [5:0] a;
        int o;
        forever begin
            @(negedge clock);
            for (int k = 0; k < 2; k++) begin
                o = own[k];
                e = '0;
                a = {s_arvalid[k], s_rready[k], arready[k][0], arready[k][1],
                     rvalid[k][0], rvalid[k][1]};
                if (!reset && o >= 0) begin
                    if (!adone[k]) begin
                        e[5]     = arvalid[o];
                        e[3 - o] = s_arready;
                    end else begin
                        e[4]     = rready[o];
                        e[1 - o] = s_rvalid;
                    end
                end
                chk($sformatf("ctrl[%0d]", k), 64'(a), 64'(e));
                if (!reset && o >= 0 && !adone[k])
                    chk($sformatf("ar_fields[%0d]", k),
                        64'({s_araddr[k], s_arid[k], s_arlen[k], s_arsize[k], s_arburst[k]}),
                        64'({araddr[o], arid[o], arlen[o], arsize[o], arburst[o]}));
                if (!reset && o >= 0 && adone[k] && s_rvalid)
                    chk($sformatf("r_fields[%0d]", k),
                        64'({rdata[k][o], rresp[k][o], rlast[k][o], rid[k][o]}),
                        64'({s_rdata, s_rresp, s_rlast, s_rid}));
            end
        end
    end

    // handshakes seen on instance 0 drive the reactive stimulus
    bit [1:0] hs_ar;
    bit       hs_sar;
    bit       hs_r;
    int       sar_len;
    always @(negedge clock) begin
        hs_ar   = arvalid & arready[0];
        hs_sar  = s_arvalid[0] && s_arready;
        hs_r    = s_rvalid && s_rready[0];
        sar_len = int'(s_arlen[0]);
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic new_req(input int j, input logic [31:0] addr, input logic [7:0] len);
        arvalid[j] = 1'b1;
        araddr[j]  = addr;
        arlen[j]   = len;
        arid[j]    = 4'($urandom);
        arsize[j]  = 3'd2;
        arburst[j] = 2'd1;
    endtask

    // everything is driven active during reset; no handshake may leak out
    task automatic do_reset();
        reset = 1'b1;
        arvalid = 2'b11; rready = 2'b11; s_arready = 1'b1; s_rvalid = 1'b1; s_rlast = 1'b1;
        step();
        step();
        chk("rst_ctrl", 64'({s_arvalid, s_rready, arready, rvalid}), 64'd0);
        reset = 1'b0;
        arvalid = '0; rready = '0; s_arready = 1'b0; s_rvalid = 1'b0; s_rlast = 1'b0;
        s_rresp = 2'd0;
    endtask

    initial begin : stim
        int beats;
        int e0 [4];
        int e1 [4];
        e0 = '{0, 1, 0, 1};
        e1 = '{1, 1, 1, 1};

        // single m0 read, address one cycle after request
        do_reset();
        new_req(0, 32'h0200_0000, 8'd0);
        s_arready = 1'b1;
        @(negedge clock);
        chk("lat_N_s_arvalid", 64'(s_arvalid[0]), 64'd0);
        step();
        @(negedge clock);
        chk("lat_N1_s_arvalid", 64'(s_arvalid[0]), 64'd1);
        chk("lat_N1_araddr", 64'(s_araddr[0]), 64'h0200_0000);
        chk("lat_N1_m0_arready", 64'(arready[0][0]), 64'd1);
        step();
        arvalid[0] = 1'b0; rready[0] = 1'b1;
        s_rvalid = 1'b1; s_rdata = 32'h1234; s_rlast = 1'b1;
        @(negedge clock);
        chk("single_m0_rdata", 64'(rdata[0][0]), 64'h1234);
        chk("single_m0_rvalid_rlast", 64'({rvalid[0][0], rlast[0][0]}), 64'b11);
        chk("single_m1_rvalid", 64'(rvalid[0][1]), 64'd0);
        step();
        s_rvalid = 1'b0;
        step();

        // continuous ties: grant order per arbitration policy
        do_reset();
        arvalid = 2'b11; araddr[0] = 32'h100; araddr[1] = 32'h200;
        rready = 2'b11; s_arready = 1'b1; s_rvalid = 1'b1; s_rlast = 1'b1;
        for (int c = 0; c < 13; c++) step();
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("tie_rr_grant%0d", i), 64'(gq0.size() > i ? gq0[i] : 9), 64'(e0[i]));
            chk($sformatf("tie_fix_grant%0d", i), 64'(gq1.size() > i ? gq1[i] : 9), 64'(e1[i]));
        end

        // m1 burst of 4 while m0 waits
        do_reset();
        new_req(1, 32'h8000, 8'd3);
        s_arready = 1'b1;
        step();
        new_req(0, 32'h4000, 8'd0);
        step();
        arvalid[1] = 1'b0; rready[1] = 1'b1; s_rvalid = 1'b1;
        for (int b = 1; b <= 4; b++) begin
            s_rlast = (b == 4);
            s_rdata = 32'($urandom);
            @(negedge clock);
            chk($sformatf("burst_b%0d_m1", b), 64'({rvalid[0][1], rlast[0][1]}), 64'({1'b1, b == 4}));
            chk($sformatf("burst_b%0d_m0", b), 64'({arready[0][0], rvalid[0][0]}), 64'd0);
            step();
        end
        s_rvalid = 1'b0; s_rlast = 1'b0;
        @(negedge clock);
        chk("burst_bubble_m0_arready", 64'(arready[0][0]), 64'd0);
        step();
        step();

        // error response passes through and still ends the read
        do_reset();
        new_req(0, 32'h10, 8'd0);
        s_arready = 1'b1;
        step();
        step();
        arvalid[0] = 1'b0; rready[0] = 1'b1;
        s_rvalid = 1'b1; s_rlast = 1'b1; s_rresp = 2'b10;
        @(negedge clock);
        chk("slverr_rresp", 64'({rvalid[0][0], rresp[0][0]}), 64'({1'b1, 2'b10}));
        step();
        @(negedge clock);
        chk("slverr_back_idle", 64'({s_rready[0], rvalid[0][0]}), 64'd0);
        s_rresp = 2'b00;

        // reset after beat 1 of 4 abandons the burst
        do_reset();
        new_req(0, 32'h20, 8'd3);
        s_arready = 1'b1;
        step();
        step();
        arvalid[0] = 1'b0; rready[0] = 1'b1; s_rvalid = 1'b1; s_rlast = 1'b0;
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        @(negedge clock);
        chk("midreset_idle", 64'({s_rready[0], arready[0], rvalid[0]}), 64'd0);
        step();

        // randomized traffic
        arvalid = '0; rready = '0; s_rvalid = 1'b0; s_rlast = 1'b0;
        beats = 0;
        for (int c = 0; c < 4000; c++) begin
            reset = ($urandom_range(399, 0) == 0);
            for (int j = 0; j < 2; j++) begin
                if (arvalid[j]) begin
                    if (hs_ar[j]) begin
                        if ($urandom_range(1, 0) == 1) new_req(j, 32'($urandom), 8'($urandom_range(3, 0)));
                        else arvalid[j] = 1'b0;
                    end else if ($urandom_range(63, 0) == 0) begin
                        arvalid[j] = 1'b0;
                    end
                end else if ($urandom_range(9, 0) < 4) begin
                    new_req(j, 32'($urandom), 8'($urandom_range(3, 0)));
                end
                rready[j] = ($urandom_range(3, 0) != 0);
            end
            if (reset) beats = 0;
            else if (hs_sar) beats = sar_len + 1;
            else if (hs_r && beats > 0) beats--;
            s_arready = ($urandom_range(4, 0) < 3);
            s_rdata   = 32'($urandom);
            s_rresp   = 2'($urandom);
            s_rid     = 4'($urandom);
            if (beats > 0) begin
                s_rvalid = ($urandom_range(9, 0) < 7);
                s_rlast  = (beats == 1);
            end else begin
                s_rvalid = ($urandom_range(19, 0) == 0);
                s_rlast  = 1'($urandom);
            end
            step();
        end
        reset = 1'b0;
        step();
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/axi_rd_arbiter.md
AXI_RD_ARBITER -- requirements
Module: axi_rd_arbiter

Interface
REQ-001 SHALL have parameter FIXED_PRIO, default 0: 0 = round-robin between m0 and m1; 1 = m1 always wins simultaneous requests.
REQ-002 SHALL have port clock, input, 1: sole clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1: reset, synchronous and active-high.
REQ-004 SHALL have ports m0_araddr/arvalid/arid/arlen/arsize/arburst, inputs, 32/1/4/8/3/2: master 0 (IFU) read address channel.
REQ-005 SHALL have port m0_arready, output, 1: master 0 address accepted.
REQ-006 SHALL have port m0_rready, input, 1: master 0 read data ready.
REQ-007 SHALL have ports m0_rdata/rresp/rvalid/rlast/rid, outputs, 32/2/1/1/4: master 0 read data channel.
REQ-008 SHALL have ports m1_* identical to REQ-004..007: master 1 (LSU).
REQ-009 SHALL have ports s_araddr/arvalid/arid/arlen/arsize/arburst, outputs, 32/1/4/8/3/2: shared downstream read address channel (memory/CLINT).
REQ-010 SHALL have port s_arready, input, 1: downstream address accepted.
REQ-011 SHALL have ports s_rdata/rresp/rvalid/rlast/rid, inputs, 32/2/1/1/4: downstream read data channel.
REQ-012 SHALL have port s_rready, output, 1: downstream data ready.

Function
REQ-013 SHALL implement FSM states IDLE, ADDR, DATA plus a 1-bit grant register gnt (0 = m0, 1 = m1) and 1-bit last-winner pointer lst.
REQ-014 IDLE: if any mX_arvalid, SHALL load gnt and go to ADDR next cycle; else stay IDLE.
REQ-015 Arbitration, one requester valid: that requester wins.
REQ-016 Arbitration, both valid, FIXED_PRIO=0: winner = !lst; FIXED_PRIO=1: winner = m1.
REQ-017 ADDR: s_ar* SHALL equal the granted master's ar* fields; s_arvalid = granted mX_arvalid; granted mX_arready = s_arready; on s_arvalid&s_arready go to DATA.
REQ-018 DATA: granted mX_r* SHALL equal s_r*; s_rready = granted mX_rready; on s_rvalid&s_rready&s_rlast go to IDLE and set lst <= gnt.
REQ-019 Non-granted master SHALL see arready=0 and rvalid=0 in all states; all arready=0 and s_arvalid=0 in IDLE and DATA.
REQ-020 Latency: arvalid first high in cycle N (state IDLE) -> s_arvalid high in cycle N+1; zero added latency on R beats.
REQ-021 Bursts (arlen>0) SHALL hold grant for all arlen+1 beats; only the rlast beat ends the transaction.
REQ-022 rresp SLVERR/DECERR SHALL pass through unchanged; transaction still ends only on rlast handshake.
REQ-023 Granted master dropping arvalid in ADDR (protocol violation) SHALL keep state ADDR; no timeout.
REQ-024 New request arriving in the same cycle the rlast handshake completes SHALL be arbitrated in the following IDLE cycle (one idle bubble between transactions).
REQ-025 s_rid/s_rdata SHALL be forwarded unmodified; block performs no ID remapping.

Reset
REQ-026 On reset SHALL set state=IDLE, gnt=0, lst=1 (m0 wins first tie).
REQ-027 During and one cycle after reset: s_arvalid=0, s_rready=0, m0/m1 arready=0, rvalid=0.
REQ-028 Reset mid-transaction SHALL abandon it immediately; outstanding downstream beats after reset are not routed (s_rready=0 in IDLE).

Verification
REQ-029 m0 only, araddr=0x2000000 arlen=0, slave returns 0x1234 -> s_arvalid at N+1, m0 gets rdata=0x1234 rlast=1, m1 rvalid stays 0.
REQ-030 m0,m1 both valid every cycle, FIXED_PRIO=0, 4 single-beat reads -> grant order m0,m1,m0,m1.
REQ-031 Same stimulus, FIXED_PRIO=1 -> grant order m1,m1,m1,m1; m0 starves while m1 requests.
REQ-032 m1 burst arlen=3 while m0 requests -> m1 receives 4 beats, rlast on beat 4 only; m0 arready=0 until then.
REQ-033 Slave rresp=2'b10 on single beat -> granted master sees rresp=2'b10, FSM returns IDLE.
REQ-034 Reset asserted in DATA after beat 1 of 4 -> next cycle state IDLE, s_rready=0, all arready=0.
